// File: rtl/mux_sched_pkg.sv
// Shared types for the 8:1 mux round-robin scheduler.
// State encoding, source count and select type.
package mux_sched_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } sched_state_e;

endpackage

// File: rtl/mux_rr_pick.sv
// Wrap-around priority search over the request vector.
// Fixed mode searches from index 0, round-robin from ptr.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  sel_t             ptr,
  input  logic             prio_mode,
  output sel_t             idx,
  output logic             any
);

  // first set bit at or after the search base, wrapping
  always_comb begin
    sel_t base;
    sel_t k;
    logic found;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    base  = prio_mode ? sel_t'(0) : ptr;
    k     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      k = base + sel_t'(i);
      if (!found && req[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Shares one 8:1 bit mux among 8 requesters.
// Grant, settle, capture, then hold for a valid/ready consumer.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_in,
  input  logic             prio_mode_in,
  input  logic [N_SRC-1:0] req_in,
  input  logic             mux_out_in,
  output sel_t             selection_out,
  output logic [N_SRC-1:0] gnt_out,
  output logic             sample_valid,
  output logic             sample_data,
  output sel_t             sample_src,
  input  logic             out_ready_in
);

  sched_state_e state;
  sel_t         rr_ptr;
  logic [1:0]   cnt;
  sel_t         pick_idx;
  logic         pick_any;

  rr_pick u_pick (
    .req       (req_in),
    .ptr       (rr_ptr),
    .prio_mode (prio_mode_in),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  // scheduler FSM; selection_out doubles as the current grant index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      selection_out <= '0;
      gnt_out       <= '0;
      sample_valid  <= 1'b0;
      sample_data   <= 1'b0;
      sample_src    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en_in && pick_any) begin
            selection_out <= pick_idx;
            gnt_out       <= N_SRC'(1) << pick_idx;
            cnt           <= 2'(SETTLE_CYC - 1);
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else             state <= CAPTURE;
        end
        CAPTURE: begin
          sample_data  <= mux_out_in;
          sample_src   <= selection_out;
          sample_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (out_ready_in) begin
            sample_valid <= 1'b0;
            gnt_out      <= '0;
            rr_ptr       <= selection_out + sel_t'(1);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler with a behavioural 8:1 mux.
// Table of transactions plus hand sequences for stall, en drop, reset.
module tb_mux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_in;
  logic       prio_mode_in;
  logic [7:0] req_in;
  logic       mux_out_in;
  logic [2:0] selection_out;
  logic [7:0] gnt_out;
  logic       sample_valid;
  logic       sample_data;
  logic [2:0] sample_src;
  logic       out_ready_in;

  logic [7:0] data_in = 8'b1010_0101;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_out_in = data_in[selection_out];

  mux_rr_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_in         (en_in),
    .prio_mode_in  (prio_mode_in),
    .req_in        (req_in),
    .mux_out_in    (mux_out_in),
    .selection_out (selection_out),
    .gnt_out       (gnt_out),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_src    (sample_src),
    .out_ready_in  (out_ready_in)
  );

  typedef struct {
    logic [7:0] req;
    logic       prio;
    logic [2:0] src;
    logic       dat;
    int         lat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // apply request, wait for valid, check sample (no handshake here)
  task automatic txn(input logic [7:0] r, input logic p,
                     input logic [2:0] esrc, input logic edat,
                     input int lat);
    int n;
    n = 0;
    req_in       = r;
    prio_mode_in = p;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 20);
    chk("valid", int'(sample_valid), 1);
    if (lat > 0) chk("latency", n, lat);
    chk("src", int'(sample_src), int'(esrc));
    chk("data", int'(sample_data), int'(edat));
    chk("sel", int'(selection_out), int'(esrc));
    chk("gnt", int'(gnt_out), int'(8'd1 << esrc));
  endtask

  task automatic drain();
    out_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid", int'(sample_valid), 0);
    chk("drain_gnt", int'(gnt_out), 0);
  endtask

  initial begin
    tbl[0]  = '{8'hFF, 1'b0, 3'd0, 1'b1, 3};
    tbl[1]  = '{8'hFF, 1'b0, 3'd1, 1'b0, 4};
    tbl[2]  = '{8'hFF, 1'b0, 3'd2, 1'b1, 4};
    tbl[3]  = '{8'hFF, 1'b0, 3'd3, 1'b0, 4};
    tbl[4]  = '{8'hFF, 1'b0, 3'd4, 1'b0, 4};
    tbl[5]  = '{8'hFF, 1'b0, 3'd5, 1'b1, 4};
    tbl[6]  = '{8'hFF, 1'b0, 3'd6, 1'b0, 4};
    tbl[7]  = '{8'hFF, 1'b0, 3'd7, 1'b1, 4};
    tbl[8]  = '{8'hFF, 1'b0, 3'd0, 1'b1, 4};
    tbl[9]  = '{8'h81, 1'b0, 3'd7, 1'b1, 4};
    tbl[10] = '{8'h81, 1'b0, 3'd0, 1'b1, 4};
    tbl[11] = '{8'h81, 1'b1, 3'd0, 1'b1, 4};
    tbl[12] = '{8'h81, 1'b1, 3'd0, 1'b1, 4};
    tbl[13] = '{8'h60, 1'b1, 3'd5, 1'b1, 4};
    tbl[14] = '{8'h24, 1'b0, 3'd2, 1'b1, 4};

    rst_n        = 1'b0;
    en_in        = 1'b1;
    prio_mode_in = 1'b0;
    req_in       = 8'h00;
    out_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // no requests: nothing ever granted
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_gnt", int'(gnt_out), 0);
      chk("idle_valid", int'(sample_valid), 0);
      chk("idle_sel", int'(selection_out), 0);
    end

    // back-to-back transactions, ready tied high
    for (int i = 0; i < 15; i++)
      txn(tbl[i].req, tbl[i].prio, tbl[i].src, tbl[i].dat, tbl[i].lat);
    req_in = 8'h00;
    drain();

    // consumer stalls: sample and select stay stable
    out_ready_in = 1'b0;
    txn(8'h08, 1'b0, 3'd3, 1'b0, 3);
    req_in = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", int'(sample_valid), 1);
      chk("stall_data", int'(sample_data), 0);
      chk("stall_src", int'(sample_src), 3);
      chk("stall_sel", int'(selection_out), 3);
    end
    drain();
    txn(8'hFF, 1'b0, 3'd4, 1'b0, 3);
    req_in = 8'h00;
    drain();

    // one-cycle request pulse, enable dropped during settle
    req_in = 8'h20;
    en_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_in = 1'b0;
    txn(8'h00, 1'b0, 3'd5, 1'b1, 2);
    drain();
    req_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_gnt", int'(gnt_out), 0);
      chk("dis_valid", int'(sample_valid), 0);
    end
    req_in = 8'h00;
    en_in  = 1'b1;

    // reset while holding a sample
    out_ready_in = 1'b0;
    txn(8'h04, 1'b0, 3'd2, 1'b1, 3);
    req_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_gnt", int'(gnt_out), 0);
    chk("rst_sel", int'(selection_out), 0);
    chk("rst_data", int'(sample_data), 0);
    chk("rst_src", int'(sample_src), 0);
    @(negedge clk);
    rst_n        = 1'b1;
    out_ready_in = 1'b1;
    txn(8'hFF, 1'b0, 3'd0, 1'b1, 3);
    req_in = 8'h00;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
